// File: rtl/button_capture.sv
// button_capture: synchronizes and debounces one pushbutton, and on each
// confirmed press latches the synchronized switch byte, pulses valid for one
// cycle and increments a wrapping 8-bit press counter.
module button_capture #(
   parameter int DB_CYCLES = 1000000,
   parameter int DB_W      = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       button,
   input  logic [7:0] switches,
   output logic [7:0] value,
   output logic       valid,
   output logic       pressed,
   output logic [7:0] press_count
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

   // Two-flop synchronizer outputs (button and switch bank)
   logic       btn_m_q, btn_s_q;
   logic [7:0] sw_m_q, sw_s_q;

   state_t          state_q, state_d;
   logic [DB_W-1:0] cnt_q, cnt_d;
   logic [7:0]      value_q, value_d;
   logic            valid_q, valid_d;
   logic            pressed_q, pressed_d;
   logic [7:0]      count_q, count_d;

   // Bring the asynchronous pins into the clock domain through two flops each
   always_ff @(posedge clock) begin
      if (reset) begin
         btn_m_q <= 1'b0;
         btn_s_q <= 1'b0;
         sw_m_q  <= 8'h00;
         sw_s_q  <= 8'h00;
      end else begin
         btn_m_q <= button;
         btn_s_q <= btn_m_q;
         sw_m_q  <= switches;
         sw_s_q  <= sw_m_q;
      end
   end

   // Debounce FSM next state, counter and press-acceptance side effects
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      value_d   = value_q;
      valid_d   = 1'b0;
      count_d   = count_q;
      case (state_q)
         IDLE: begin
            if (btn_s_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               value_d = sw_s_q;
               valid_d = 1'b1;
               count_d = count_q + 8'd1;
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end
         PRESSED: begin
            if (!btn_s_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s_q) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
   end

   // FSM state, debounce counter and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         value_q   <= 8'h00;
         valid_q   <= 1'b0;
         pressed_q <= 1'b0;
         count_q   <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         value_q   <= value_d;
         valid_q   <= valid_d;
         pressed_q <= pressed_d;
         count_q   <= count_d;
      end
   end

   assign value       = value_q;
   assign valid       = valid_q;
   assign pressed     = pressed_q;
   assign press_count = count_q;

endmodule

// File: tb/tb_button_capture.sv
// Directed bench for button_capture with DB_CYCLES=4: reset, clean press and
// release latency, bounce rejection, release glitch, counter wrap and
// reset during debounce.
module tb_button_capture;

   logic       clock;
   logic       reset;
   logic       button;
   logic [7:0] switches;
   logic [7:0] value;
   logic       valid;
   logic       pressed;
   logic [7:0] press_count;

   int checks;
   int errors;
   int nv;
   int np;

   button_capture #(
      .DB_CYCLES (4),
      .DB_W      (3)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .button      (button),
      .switches    (switches),
      .value       (value),
      .valid       (valid),
      .pressed     (pressed),
      .press_count (press_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle before sampling
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Run n edges, counting samples with valid=1 and with pressed=1
   task automatic run(input int n, output int nvld, output int nprs);
      nvld = 0;
      nprs = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (valid === 1'b1) nvld++;
         if (pressed === 1'b1) nprs++;
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      button = 1'b0;
      tick();
      tick();
      reset  = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      button   = 1'b0;
      switches = 8'h00;

      // 1: reset with random pins
      for (int k = 0; k < 3; k++) begin
         button   = 1'($urandom);
         switches = 8'($urandom);
         tick();
      end
      chk("rst_value", 32'(value), 32'h00);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_pressed", 32'(pressed), 32'h0);
      chk("rst_count", 32'(press_count), 32'h00);
      button   = 1'b0;
      switches = 8'h00;
      reset    = 1'b0;
      run(4, nv, np);
      chk("idle_novalid", 32'(nv), 32'd0);

      // 2: clean press, latency DB_CYCLES+3 = 7 edges
      switches = 8'hA5;
      button   = 1'b1;
      run(6, nv, np);
      chk("press_early_valid", 32'(nv), 32'd0);
      chk("press_early_pressed", 32'(np), 32'd0);
      tick();
      chk("press_valid_e7", 32'(valid), 32'h1);
      chk("press_pressed_e7", 32'(pressed), 32'h1);
      chk("press_value", 32'(value), 32'hA5);
      chk("press_count1", 32'(press_count), 32'd1);
      tick();
      chk("press_valid_drop", 32'(valid), 32'h0);
      run(12, nv, np);
      chk("hold_novalid", 32'(nv), 32'd0);
      chk("hold_pressed", 32'(np), 32'd12);
      button = 1'b0;
      run(6, nv, np);
      chk("rel_early_pressed", 32'(np), 32'd6);
      tick();
      chk("rel_pressed_e7", 32'(pressed), 32'h0);
      chk("rel_count", 32'(press_count), 32'd1);
      chk("rel_value_hold", 32'(value), 32'hA5);

      // switch change alone gives no valid and keeps value
      switches = 8'h11;
      run(6, nv, np);
      chk("sw_only_novalid", 32'(nv), 32'd0);
      chk("sw_only_value", 32'(value), 32'hA5);

      // 3: bounce 1,1,0 x10 then held high
      do_reset();
      switches = 8'h3C;
      nv = 0;
      np = 0;
      for (int r = 0; r < 10; r++) begin
         int a, b;
         button = 1'b1;
         run(2, a, b);
         nv += a;
         np += b;
         button = 1'b0;
         run(1, a, b);
         nv += a;
         np += b;
      end
      chk("bounce_novalid", 32'(nv), 32'd0);
      chk("bounce_nopressed", 32'(np), 32'd0);
      button = 1'b1;
      run(12, nv, np);
      chk("bounce_one_valid", 32'(nv), 32'd1);
      chk("bounce_value", 32'(value), 32'h3C);
      chk("bounce_count", 32'(press_count), 32'd1);
      chk("bounce_pressed", 32'(pressed), 32'h1);

      // 4: short release glitch while pressed
      begin
         int a, b;
         button = 1'b0;
         run(2, a, b);
         button = 1'b1;
         run(10, nv, np);
         nv += a;
         np += b;
      end
      chk("glitch_novalid", 32'(nv), 32'd0);
      chk("glitch_pressed", 32'(np), 32'd12);
      chk("glitch_count", 32'(press_count), 32'd1);
      button = 1'b0;
      run(10, nv, np);
      chk("glitch_released", 32'(pressed), 32'h0);

      // 5: 256 presses, counter wrap
      do_reset();
      nv = 0;
      for (int i = 0; i < 256; i++) begin
         int a, b;
         switches = 8'(i);
         button   = 1'b1;
         run(9, a, b);
         nv += a;
         button = 1'b0;
         run(9, a, b);
         nv += a;
         if (i == 254) begin
            chk("wrap_count_255", 32'(press_count), 32'hFF);
            chk("wrap_value_255", 32'(value), 32'hFE);
         end
      end
      chk("wrap_count_256", 32'(press_count), 32'h00);
      chk("wrap_value_256", 32'(value), 32'hFF);
      chk("wrap_valids", 32'(nv), 32'd256);

      // 6: reset during debounce discards the pending press
      do_reset();
      switches = 8'h5A;
      button   = 1'b1;
      run(4, nv, np);
      chk("pre_rst_novalid", 32'(nv), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_count", 32'(press_count), 32'd0);
      run(6, nv, np);
      chk("post_rst_early", 32'(nv), 32'd0);
      tick();
      chk("post_rst_valid_e7", 32'(valid), 32'h1);
      chk("post_rst_count", 32'(press_count), 32'd1);
      chk("post_rst_value", 32'(value), 32'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
